// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with operand forwarding, load-use bubble insertion,
// downstream-stall hold (with operand refresh while held) and flush.
module id_ex_stage #(
    parameter int DW = 32,
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          id_valid,
    input  logic [AW-1:0] id_op1,
    input  logic [AW-1:0] id_op2,
    input  logic [AW-1:0] id_dReg,
    input  logic [DW-1:0] id_rdData1,
    input  logic [DW-1:0] id_rdData2,
    input  logic [DW-1:0] id_imm,
    input  logic [7:0]    id_ctrl,
    input  logic          ex_stall,
    input  logic          flush,
    input  logic          mem_we,
    input  logic [AW-1:0] mem_dReg,
    input  logic [DW-1:0] mem_data,
    input  logic          wb_we,
    input  logic [AW-1:0] wb_dReg,
    input  logic [DW-1:0] wb_data,
    output logic          ex_valid,
    output logic [DW-1:0] ex_opA,
    output logic [DW-1:0] ex_opB,
    output logic [DW-1:0] ex_imm,
    output logic [AW-1:0] ex_dReg,
    output logic [7:0]    ex_ctrl,
    output logic          id_stall,
    output logic [15:0]   stall_count
);

    // r14/r15 are write-protected in the register file, so a pending write
    // to them never lands and must not be forwarded.
    localparam logic [AW-1:0] PROT_A = AW'(14);
    localparam logic [AW-1:0] PROT_B = AW'(15);

    logic          r_valid;
    logic [DW-1:0] r_opA;
    logic [DW-1:0] r_opB;
    logic [DW-1:0] r_imm;
    logic [AW-1:0] r_dReg;
    logic [7:0]    r_ctrl;
    logic [AW-1:0] r_src1;
    logic [AW-1:0] r_src2;
    logic [15:0]   r_stall_count;

    logic          w_mem_elig;
    logic          w_wb_elig;
    logic          w_hold;
    logic          w_load_use;
    logic [DW-1:0] w_capA;
    logic [DW-1:0] w_capB;
    logic [DW-1:0] w_holdA;
    logic [DW-1:0] w_holdB;

    // Operand select: MEM result is newer than WB, so it wins when both match.
    function automatic logic [DW-1:0] fwd_sel(
        input logic [AW-1:0] src,
        input logic [DW-1:0] dflt,
        input logic          m_ok,
        input logic [AW-1:0] m_reg,
        input logic [DW-1:0] m_dat,
        input logic          w_ok,
        input logic [AW-1:0] w_reg,
        input logic [DW-1:0] w_dat
    );
        if (m_ok && (m_reg == src))
            return m_dat;
        else if (w_ok && (w_reg == src))
            return w_dat;
        else
            return dflt;
    endfunction

    // Forwarding eligibility, hazard detection and operand candidates.
    always_comb begin
        w_mem_elig = mem_we && (mem_dReg != PROT_A) && (mem_dReg != PROT_B);
        w_wb_elig  = wb_we  && (wb_dReg  != PROT_A) && (wb_dReg  != PROT_B);
        // A bubble (r_valid = 0) never blocks and never causes a hazard.
        w_hold     = ex_stall && r_valid;
        w_load_use = r_valid && r_ctrl[1] && r_ctrl[0] && id_valid &&
                     ((r_dReg == id_op1) || (r_dReg == id_op2));
        w_capA  = fwd_sel(id_op1, id_rdData1, w_mem_elig, mem_dReg, mem_data,
                          w_wb_elig, wb_dReg, wb_data);
        w_capB  = fwd_sel(id_op2, id_rdData2, w_mem_elig, mem_dReg, mem_data,
                          w_wb_elig, wb_dReg, wb_data);
        // While held, keep refreshing operands so a result retiring during the
        // stall is not lost.
        w_holdA = fwd_sel(r_src1, r_opA, w_mem_elig, mem_dReg, mem_data,
                          w_wb_elig, wb_dReg, wb_data);
        w_holdB = fwd_sel(r_src2, r_opB, w_mem_elig, mem_dReg, mem_data,
                          w_wb_elig, wb_dReg, wb_data);
    end

    // Stage register: flush > downstream hold > load-use bubble > capture.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_valid       <= 1'b0;
            r_opA         <= '0;
            r_opB         <= '0;
            r_imm         <= '0;
            r_dReg        <= '0;
            r_ctrl        <= '0;
            r_src1        <= '0;
            r_src2        <= '0;
            r_stall_count <= '0;
        end else if (flush) begin
            r_valid <= 1'b0;
        end else if (w_hold) begin
            r_opA <= w_holdA;
            r_opB <= w_holdB;
        end else if (w_load_use) begin
            r_valid <= 1'b0;
            if (r_stall_count != 16'hFFFF)
                r_stall_count <= r_stall_count + 16'd1;
        end else begin
            r_valid <= id_valid;
            r_opA   <= w_capA;
            r_opB   <= w_capB;
            r_imm   <= id_imm;
            r_dReg  <= id_dReg;
            r_ctrl  <= id_ctrl;
            r_src1  <= id_op1;
            r_src2  <= id_op2;
        end
    end

    assign ex_valid    = r_valid;
    assign ex_opA      = r_opA;
    assign ex_opB      = r_opB;
    assign ex_imm      = r_imm;
    assign ex_dReg     = r_dReg;
    assign ex_ctrl     = r_ctrl;
    assign stall_count = r_stall_count;
    assign id_stall    = w_load_use || w_hold;

endmodule
